tage_ubit_reset_ctrl: RTL
=========================

Name: tage_ubit_reset_ctrl

Overview:
- Scheduler for the periodic graceful reset of the 2-bit useful (u) counters in the TAGE tagged tables.
- Counts committed branch updates. Every 2^PERIOD_LOG updates it sweeps all table indices and clears one u bit per entry, alternating MSB and LSB on successive sweeps.
- Drives a shared u-bit clear port on the tagged tables. Normal predictor updates have priority on that port, signalled by withholding reset_gnt_i.
- A forced sweep (e.g. from a CSR or flush) clears both u bits.

Parameters:
- TABLE_DEPTH, 1024, entries per tagged table; must be a power of two, at least 2.
- PERIOD_LOG, 18, log2 of the number of committed updates between periodic sweeps; at least 2.
- IDX_W, $clog2(TABLE_DEPTH), index width; derived, not overridden.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- update_valid_i  in  1  one committed conditional-branch update this cycle.
- force_i  in  1  single-cycle request for a full clear sweep (both u bits).
- reset_gnt_i  in  1  table clear port accepted the current request this cycle.
- reset_req_o  out  1  clear request valid.
- reset_idx_o  out  IDX_W  entry index to clear, applied to all tagged tables in parallel.
- reset_mask_o  out  2  u bits to clear: 2'b10 = MSB, 2'b01 = LSB, 2'b11 = both; 2'b00 when idle.
- busy_o  out  1  sweep in progress.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - reset_req_o = 0, reset_idx_o = 0, reset_mask_o = 2'b00, busy_o = 0.
  - Branch counter = 0, index = 0, phase_q = 1 (first periodic sweep clears the MSB).
  - pend_periodic = 0, pend_force = 0, state = IDLE.
- Branch counter:
  - PERIOD_LOG bits wide; increments by 1 when update_valid_i is high, in every state.
  - A wrap event occurs when the counter is all-ones and update_valid_i is high; the counter wraps to 0.
- States: IDLE, SWEEP. Outputs are registered-state derived:
  - reset_req_o = busy_o = (state == SWEEP).
  - reset_mask_o = mode_q in SWEEP, 2'b00 in IDLE.
  - reset_idx_o = idx_q.
- IDLE to SWEEP transitions:
  - In IDLE, if force_i or pend_force: next state is SWEEP with mode_q = 2'b11. Clears pend_force and pend_periodic. A wrap in the same cycle is absorbed.
  - Else, if a wrap occurs or pend_periodic is set: next state is SWEEP with mode_q = phase_q ? 2'b10 : 2'b01. Clears pend_periodic.
  - Latency: event in cycle N gives reset_req_o high in cycle N+1 with idx 0.
- SWEEP:
  - reset_idx_o, reset_mask_o and reset_req_o are held stable until reset_gnt_i.
  - On grant with idx_q < TABLE_DEPTH-1: idx_q increments.
  - On grant with idx_q = TABLE_DEPTH-1: idx_q returns to 0 and state returns to IDLE. phase_q toggles only if mode_q was a single-bit mask; a 2'b11 sweep leaves phase_q unchanged.
  - No grant: hold; there is no timeout.
- Events during SWEEP:
  - A wrap sets pend_periodic.
  - force_i sets pend_force.
  - A second event of the same kind is merged; each pending flag is 1 bit.
  - The sweep in progress is never aborted or restarted.
- Back-to-back sweeps: if a flag is pending when a sweep completes, the IDLE cycle evaluates it, giving exactly one IDLE cycle between sweeps. Force has priority over periodic. A force sweep also consumes a pending periodic flag.
- Reset mid-sweep: all state returns to reset values immediately. No partial-sweep resume.
- Minimum sweep length is TABLE_DEPTH cycles (grant held high).

Test Plan (TABLE_DEPTH=8, PERIOD_LOG=4):
1. Reset, then hold update_valid_i=1 for 16 cycles with reset_gnt_i=1. The cycle after the 16th update: req=1, idx=0, mask=2'b10. idx steps 0..7 over 8 cycles, then busy_o=0.
2. Repeat another 16 updates: second sweep has mask=2'b01. Third sweep has mask=2'b10 (alternation).
3. During a sweep, toggle reset_gnt_i 0/1 every cycle: idx advances only on gnt cycles, outputs stay stable while gnt=0, and the sweep takes 16 cycles.
4. Pulse force_i in IDLE: one 8-entry sweep with mask=2'b11. A following periodic sweep still uses the pre-force phase.
5. Make a wrap and force_i both occur mid-sweep: after completion, one IDLE cycle, then a single mask=2'b11 sweep. No additional periodic sweep follows.
6. Deassert rst_ni asynchronously at idx=5 mid-sweep: req=0, idx=0, mask=2'b00 immediately. Counter restarts and needs 16 updates for the next sweep, which has mask=2'b10.

Source files
------------

// File: rtl/tage_ubit_reset_ctrl.sv
// Periodic and forced graceful-reset scheduler for TAGE useful (u) counters.
// Counts committed updates and, once per 2^PERIOD_LOG of them, walks every
// table index and clears one u bit per entry, alternating MSB and LSB between
// sweeps. A forced sweep clears both bits. The clear port is shared and
// normal updates win it by withholding reset_gnt_i.
module tage_ubit_reset_ctrl #(
   parameter int unsigned TABLE_DEPTH = 1024,
   parameter int unsigned PERIOD_LOG  = 18,
   parameter int unsigned IDX_W       = $clog2(TABLE_DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             update_valid_i,
   input  logic             force_i,
   input  logic             reset_gnt_i,
   output logic             reset_req_o,
   output logic [IDX_W-1:0] reset_idx_o,
   output logic [1:0]       reset_mask_o,
   output logic             busy_o
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SWEEP = 1'b1;

   localparam logic [1:0] MASK_MSB  = 2'b10;
   localparam logic [1:0] MASK_LSB  = 2'b01;
   localparam logic [1:0] MASK_BOTH = 2'b11;
   localparam logic [1:0] MASK_NONE = 2'b00;

   logic [0:0]            state_q, state_d;
   logic [PERIOD_LOG-1:0] cnt_q;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [1:0]            mode_q, mode_d;
   logic                  phase_q, phase_d;
   logic                  pend_periodic_q, pend_periodic_d;
   logic                  pend_force_q, pend_force_d;
   logic                  wrap;
   logic                  last_idx;

   assign wrap     = update_valid_i && (&cnt_q);
   assign last_idx = (idx_q == IDX_W'(TABLE_DEPTH - 1));

   // Free-running committed-update counter, active in every state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (update_valid_i) begin
         cnt_q <= cnt_q + PERIOD_LOG'(1);
      end
   end

   // State, sweep bookkeeping and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         idx_q           <= '0;
         mode_q          <= MASK_NONE;
         phase_q         <= 1'b1;
         pend_periodic_q <= 1'b0;
         pend_force_q    <= 1'b0;
         reset_req_o     <= 1'b0;
         busy_o          <= 1'b0;
         reset_mask_o    <= MASK_NONE;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         mode_q          <= mode_d;
         phase_q         <= phase_d;
         pend_periodic_q <= pend_periodic_d;
         pend_force_q    <= pend_force_d;
         reset_req_o     <= (state_d == SWEEP);
         busy_o          <= (state_d == SWEEP);
         reset_mask_o    <= (state_d == SWEEP) ? mode_d : MASK_NONE;
      end
   end

   assign reset_idx_o = idx_q;

   // Next-state: sweep launch priority (force over periodic), index walk,
   // and merging of events that arrive while a sweep is running.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      mode_d          = mode_q;
      phase_d         = phase_q;
      pend_periodic_d = pend_periodic_q;
      pend_force_d    = pend_force_q;

      unique case (state_q)
         IDLE: begin
            if (force_i || pend_force_q) begin
               // A wrap in this cycle is absorbed by the full clear.
               state_d         = SWEEP;
               mode_d          = MASK_BOTH;
               idx_d           = '0;
               pend_force_d    = 1'b0;
               pend_periodic_d = 1'b0;
            end else if (wrap || pend_periodic_q) begin
               state_d         = SWEEP;
               mode_d          = phase_q ? MASK_MSB : MASK_LSB;
               idx_d           = '0;
               pend_periodic_d = 1'b0;
            end
         end
         SWEEP: begin
            if (wrap) begin
               pend_periodic_d = 1'b1;
            end
            if (force_i) begin
               pend_force_d = 1'b1;
            end
            if (reset_gnt_i) begin
               if (last_idx) begin
                  idx_d   = '0;
                  state_d = IDLE;
                  // Only single-bit sweeps advance the MSB/LSB alternation.
                  if (mode_q != MASK_BOTH) begin
                     phase_d = ~phase_q;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
